// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, MIPS-I opcode/funct constants, ALU-op encoding and ID/EX control struct
package pipeline_pkg;
    localparam int PC_W    = 11;
    localparam int INSTR_W = 33;
    localparam int DATA_W  = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    reg_dst;
        alu_op_t alu_op;
    } ctl_t;
endpackage

// File: rtl/register_file.sv
// register_file: 32x32 register file, r0 hardwired to 0, write-through bypass, sync active-low clear
//   clock/reset_n; ra/rb read addresses -> da/db; we/wa/wd write port
module register_file
    import pipeline_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [4:0]        ra,
    input  logic [4:0]        rb,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] da,
    output logic [DATA_W-1:0] db
);
    logic [DATA_W-1:0] regs [32];
    logic              wr;

    assign wr = we && wa != 5'd0;

    always_ff @(posedge clock)
        if (!reset_n) regs <= '{default: '0};
        else if (wr) regs[wa] <= wd;

    assign da = ra == 5'd0 ? '0 : (wr && wa == ra) ? wd : regs[ra];
    assign db = rb == 5'd0 ? '0 : (wr && wa == rb) ? wd : regs[rb];
endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: ID stage - decode, register read, branch/jump resolve, hazard detect, ID/EX register
//   in : pc, instruccion (bit 32 valid), EX/MEM/WB feedback
//   out: fetch controls (combinational), ex_* ID/EX datapath and control (registered)
module instruction_decode
    import pipeline_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instruccion,
    input  logic               ex_mem_read,
    input  logic               ex_reg_write,
    input  logic [4:0]         ex_rd_dest,
    input  logic               mem_reg_write,
    input  logic               mem_mem_read,
    input  logic [4:0]         mem_rd,
    input  logic [DATA_W-1:0]  mem_dato,
    input  logic               wb_reg_write,
    input  logic [4:0]         wb_rd,
    input  logic [DATA_W-1:0]  wb_dato,
    output logic [PC_W-1:0]    pc_salto,
    output logic               salto_sel,
    output logic               if_flush,
    output logic               pc_write,
    output logic               if_id_write,
    output logic [PC_W-1:0]    ex_pc,
    output logic [DATA_W-1:0]  ex_dato_a,
    output logic [DATA_W-1:0]  ex_dato_b,
    output logic [DATA_W-1:0]  ex_inmediato,
    output logic [4:0]         ex_rs,
    output logic [4:0]         ex_rt,
    output logic [4:0]         ex_rd,
    output logic [4:0]         ex_shamt,
    output logic               ex_ctl_reg_write,
    output logic               ex_ctl_mem_read,
    output logic               ex_ctl_mem_write,
    output logic               ex_ctl_mem_to_reg,
    output logic               ex_ctl_alu_src,
    output logic               ex_ctl_reg_dst,
    output logic [3:0]         ex_ctl_alu_op
);
    logic              valid, known, rt_src, is_br, is_j, taken;
    logic              load_use, br_stall, stall, redirect, keep, fwd;
    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd, shamt;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rd_a, rd_b, cmp_a, cmp_b, imm_ext;
    ctl_t              ctl, ex_ctl;

    assign valid = instruccion[32];
    assign op    = instruccion[31:26];
    assign rs    = instruccion[25:21];
    assign rt    = instruccion[20:16];
    assign rd    = instruccion[15:11];
    assign shamt = instruccion[10:6];
    assign funct = instruccion[5:0];
    assign imm   = instruccion[15:0];

    register_file u_rf (
        .clock  (clock),
        .reset_n(reset_n),
        .ra     (rs),
        .rb     (rt),
        .we     (wb_reg_write),
        .wa     (wb_rd),
        .wd     (wb_dato),
        .da     (rd_a),
        .db     (rd_b)
    );

    always_comb begin
        ctl   = '0;
        known = 1'b1;
        case (op)
            OP_RTYPE: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: ctl.alu_op = ALU_ADD;
                    F_SUB, F_SUBU: ctl.alu_op = ALU_SUB;
                    F_AND:         ctl.alu_op = ALU_AND;
                    F_OR:          ctl.alu_op = ALU_OR;
                    F_XOR:         ctl.alu_op = ALU_XOR;
                    F_NOR:         ctl.alu_op = ALU_NOR;
                    F_SLT:         ctl.alu_op = ALU_SLT;
                    F_SLL:         ctl.alu_op = ALU_SLL;
                    F_SRL:         ctl.alu_op = ALU_SRL;
                    F_SRA:         ctl.alu_op = ALU_SRA;
                    default:       known      = 1'b0;
                endcase
            end
            OP_LW: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_read   = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.alu_src    = 1'b1;
            end
            OP_SW: begin
                ctl.mem_write = 1'b1;
                ctl.alu_src   = 1'b1;
            end
            OP_BEQ, OP_BNE: ctl.alu_op = ALU_SUB;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
                ctl.alu_op    = op == OP_SLTI ? ALU_SLT :
                                op == OP_ANDI ? ALU_AND :
                                op == OP_ORI  ? ALU_OR  :
                                op == OP_LUI  ? ALU_LUI : ALU_ADD;
            end
            OP_J:    ;
            default: known = 1'b0;
        endcase
    end

    assign imm_ext = (op == OP_ANDI || op == OP_ORI) ? {16'b0, imm} : {{16{imm[15]}}, imm};

    // rt is only a true source operand for these; I-types write rt instead
    assign rt_src = op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW;
    assign is_br  = valid && (op == OP_BEQ || op == OP_BNE);
    assign is_j   = valid && op == OP_J;

    assign load_use = valid && ex_mem_read && ex_rd_dest != 5'd0 &&
                      (ex_rd_dest == rs || (rt_src && ex_rd_dest == rt));
    // a load in MEM cannot be forwarded to the comparator, so it stalls one more cycle
    assign br_stall = is_br &&
                      ((ex_reg_write && ex_rd_dest != 5'd0 && (ex_rd_dest == rs || ex_rd_dest == rt)) ||
                       (mem_mem_read && mem_rd != 5'd0 && (mem_rd == rs || mem_rd == rt)));
    assign stall    = load_use || br_stall;

    assign fwd   = mem_reg_write && !mem_mem_read && mem_rd != 5'd0;
    assign cmp_a = (fwd && mem_rd == rs) ? mem_dato : rd_a;
    assign cmp_b = (fwd && mem_rd == rt) ? mem_dato : rd_b;
    assign taken = is_br && ((cmp_a == cmp_b) == (op == OP_BEQ));

    assign redirect    = reset_n && !stall && (taken || is_j);
    assign pc_write    = !reset_n || !stall;
    assign if_id_write = !reset_n || !stall;
    assign salto_sel   = redirect;
    assign if_flush    = redirect;
    assign pc_salto    = !redirect ? '0 : is_j ? instruccion[10:0] : pc + instruccion[10:0];

    assign keep = valid && known && !stall && !redirect;

    always_ff @(posedge clock)
        if (!reset_n) begin
            ex_pc        <= '0;
            ex_dato_a    <= '0;
            ex_dato_b    <= '0;
            ex_inmediato <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_shamt     <= '0;
            ex_ctl       <= '0;
        end else begin
            ex_pc        <= pc;
            ex_dato_a    <= rd_a;
            ex_dato_b    <= rd_b;
            ex_inmediato <= imm_ext;
            ex_rs        <= rs;
            ex_rt        <= rt;
            ex_rd        <= rd;
            ex_shamt     <= shamt;
            ex_ctl       <= keep ? ctl : '0;
        end

    assign ex_ctl_reg_write  = ex_ctl.reg_write;
    assign ex_ctl_mem_read   = ex_ctl.mem_read;
    assign ex_ctl_mem_write  = ex_ctl.mem_write;
    assign ex_ctl_mem_to_reg = ex_ctl.mem_to_reg;
    assign ex_ctl_alu_src    = ex_ctl.alu_src;
    assign ex_ctl_reg_dst    = ex_ctl.reg_dst;
    assign ex_ctl_alu_op     = ex_ctl.alu_op;
endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed vector table plus reset sequences for instruction_decode
module tb_instruction_decode;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [10:0] pc;
    logic [32:0] instruccion;
    logic        ex_mem_read, ex_reg_write, mem_reg_write, mem_mem_read, wb_reg_write;
    logic [4:0]  ex_rd_dest, mem_rd, wb_rd;
    logic [31:0] mem_dato, wb_dato;
    logic [10:0] pc_salto, ex_pc;
    logic        salto_sel, if_flush, pc_write, if_id_write;
    logic [31:0] ex_dato_a, ex_dato_b, ex_inmediato;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic        ex_ctl_reg_write, ex_ctl_mem_read, ex_ctl_mem_write, ex_ctl_mem_to_reg;
    logic        ex_ctl_alu_src, ex_ctl_reg_dst;
    logic [3:0]  ex_ctl_alu_op;
    logic [9:0]  ctl_bus;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    instruction_decode dut (
        .clock(clock), .reset_n(reset_n), .pc(pc), .instruccion(instruccion),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd_dest(ex_rd_dest),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .mem_dato(mem_dato),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_dato(wb_dato),
        .pc_salto(pc_salto), .salto_sel(salto_sel), .if_flush(if_flush),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .ex_pc(ex_pc), .ex_dato_a(ex_dato_a), .ex_dato_b(ex_dato_b), .ex_inmediato(ex_inmediato),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .ex_ctl_reg_write(ex_ctl_reg_write), .ex_ctl_mem_read(ex_ctl_mem_read),
        .ex_ctl_mem_write(ex_ctl_mem_write), .ex_ctl_mem_to_reg(ex_ctl_mem_to_reg),
        .ex_ctl_alu_src(ex_ctl_alu_src), .ex_ctl_reg_dst(ex_ctl_reg_dst), .ex_ctl_alu_op(ex_ctl_alu_op)
    );

    assign ctl_bus = {ex_ctl_reg_write, ex_ctl_mem_read, ex_ctl_mem_write, ex_ctl_mem_to_reg,
                      ex_ctl_alu_src, ex_ctl_reg_dst, ex_ctl_alu_op};

    typedef struct {
        logic [32:0] instr;
        logic [10:0] pc;
        logic        ex_mr, ex_rw;
        logic [4:0]  ex_rd;
        logic        mem_rw, mem_mr;
        logic [4:0]  mem_rd;
        logic [31:0] mem_dato;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_dato;
        logic        pw, ss;
        logic [10:0] ps;
        logic [9:0]  ctl;
        logic [31:0] da;
        logic        ci;
        logic [31:0] imm;
    } vec_t;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    localparam logic [32:0] I_ADD35 = 33'h1_00A01820;
    localparam logic [32:0] I_ADD00 = 33'h1_00001820;
    localparam logic [32:0] I_ADD10 = 33'h1_00201820;
    localparam logic [32:0] I_SUB   = 33'h1_00412022;
    localparam logic [32:0] I_SW    = 33'h1_AC220004;
    localparam logic [32:0] I_ADDI  = 33'h1_2022FFFF;
    localparam logic [32:0] I_LW    = 33'h1_8C220008;
    localparam logic [32:0] I_ANDI  = 33'h1_3022FFFF;
    localparam logic [32:0] I_BEQ12 = 33'h1_10220004;
    localparam logic [32:0] I_BEQ16 = 33'h1_10260004;
    localparam logic [32:0] I_BEQ17 = 33'h1_10270001;
    localparam logic [32:0] I_BNE12 = 33'h1_14220004;
    localparam logic [32:0] I_BNE16 = 33'h1_1426FFFE;
    localparam logic [32:0] I_J     = 33'h1_080003FF;
    localparam logic [32:0] I_JBUB  = 33'h0_080003FF;
    localparam logic [32:0] I_UNK   = 33'h1_0000003F;

    localparam logic [9:0] C_Z    = 10'b0000000000;
    localparam logic [9:0] C_RADD = 10'b1000010000;
    localparam logic [9:0] C_LW   = 10'b1101100000;
    localparam logic [9:0] C_SW   = 10'b0010100000;
    localparam logic [9:0] C_ADDI = 10'b1000100000;
    localparam logic [9:0] C_ANDI = 10'b1000100010;
    localparam logic [9:0] C_BSUB = 10'b0000000001;

    vec_t v [23];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        instruccion   = t.instr;
        pc            = t.pc;
        ex_mem_read   = t.ex_mr;
        ex_reg_write  = t.ex_rw;
        ex_rd_dest    = t.ex_rd;
        mem_reg_write = t.mem_rw;
        mem_mem_read  = t.mem_mr;
        mem_rd        = t.mem_rd;
        mem_dato      = t.mem_dato;
        wb_reg_write  = t.wb_rw;
        wb_rd         = t.wb_rd;
        wb_dato       = t.wb_dato;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        wb_reg_write = 1'b1;
        wb_rd        = r;
        wb_dato      = d;
        @(posedge clock); #1;
        wb_reg_write = 1'b0;
    endtask

    initial begin
        // registers after preload: r1=7 r2=7 r6=9; r5 and r7 are written by vectors 0 and 13
        v[0]  = '{I_ADD35, 11'h010, N,N,5'd0, N,N,5'd0,32'd0, Y,5'd5,32'h1234, Y,N,11'h000, C_RADD,32'h1234, N,32'd0};
        v[1]  = '{I_ADD00, 11'h010, N,N,5'd0, N,N,5'd0,32'd0, Y,5'd0,32'd5,    Y,N,11'h000, C_RADD,32'd0,    N,32'd0};
        v[2]  = '{I_SUB,   11'h010, Y,N,5'd2, N,N,5'd0,32'd0, N,5'd0,32'd0,    N,N,11'h000, C_Z,   32'd7,    N,32'd0};
        v[3]  = '{I_SW,    11'h011, Y,N,5'd2, N,N,5'd0,32'd0, N,5'd0,32'd0,    N,N,11'h000, C_Z,   32'd7,    N,32'd0};
        v[4]  = '{I_ADDI,  11'h012, Y,N,5'd2, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,N,11'h000, C_ADDI,32'd7,    Y,32'hFFFFFFFF};
        v[5]  = '{I_LW,    11'h013, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,N,11'h000, C_LW,  32'd7,    Y,32'd8};
        v[6]  = '{I_ANDI,  11'h014, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,N,11'h000, C_ANDI,32'd7,    Y,32'h0000FFFF};
        v[7]  = '{I_SW,    11'h015, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,N,11'h000, C_SW,  32'd7,    Y,32'd4};
        v[8]  = '{I_BEQ12, 11'h010, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,Y,11'h014, C_Z,   32'd7,    N,32'd0};
        v[9]  = '{I_BEQ16, 11'h020, N,N,5'd0, Y,N,5'd1,32'd9, N,5'd0,32'd0,    Y,Y,11'h024, C_Z,   32'd7,    N,32'd0};
        v[10] = '{I_BEQ16, 11'h020, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,N,11'h000, C_BSUB,32'd7,    N,32'd0};
        v[11] = '{I_BNE12, 11'h030, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,N,11'h000, C_BSUB,32'd7,    N,32'd0};
        v[12] = '{I_BNE16, 11'h005, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,Y,11'h003, C_Z,   32'd7,    N,32'd0};
        v[13] = '{I_BEQ17, 11'h100, N,N,5'd0, N,N,5'd0,32'd0, Y,5'd7,32'd7,    Y,Y,11'h101, C_Z,   32'd7,    N,32'd0};
        v[14] = '{I_BEQ12, 11'h010, N,Y,5'd1, N,N,5'd0,32'd0, N,5'd0,32'd0,    N,N,11'h000, C_Z,   32'd7,    N,32'd0};
        v[15] = '{I_BEQ12, 11'h010, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,Y,11'h014, C_Z,   32'd7,    N,32'd0};
        v[16] = '{I_BEQ12, 11'h040, Y,Y,5'd1, N,N,5'd0,32'd0, N,5'd0,32'd0,    N,N,11'h000, C_Z,   32'd7,    N,32'd0};
        v[17] = '{I_BEQ12, 11'h040, N,N,5'd0, Y,Y,5'd1,32'd0, N,5'd0,32'd0,    N,N,11'h000, C_Z,   32'd7,    N,32'd0};
        v[18] = '{I_BEQ12, 11'h040, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,Y,11'h044, C_Z,   32'd7,    N,32'd0};
        v[19] = '{I_J,     11'h050, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,Y,11'h3FF, C_Z,   32'd0,    N,32'd0};
        v[20] = '{I_JBUB,  11'h050, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,N,11'h000, C_Z,   32'd0,    N,32'd0};
        v[21] = '{I_UNK,   11'h060, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,N,11'h000, C_Z,   32'd0,    N,32'd0};
        v[22] = '{I_ADD35, 11'h070, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0,    Y,N,11'h000, C_RADD,32'h1234, N,32'd0};

        drive('{I_J, 11'h010, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0, N,N,11'h0, C_Z,32'd0, N,32'd0});
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("rst_pc_write", 0, 32'(pc_write), 32'd1);
        chk("rst_if_id_write", 0, 32'(if_id_write), 32'd1);
        chk("rst_salto_sel", 0, 32'(salto_sel), 32'd0);
        chk("rst_if_flush", 0, 32'(if_flush), 32'd0);
        chk("rst_pc_salto", 0, 32'(pc_salto), 32'd0);
        chk("rst_ex_any", 0, 32'(|{ex_pc, ex_dato_a, ex_dato_b, ex_inmediato, ex_rs, ex_rt, ex_rd, ex_shamt, ctl_bus}), 32'd0);

        reset_n     = 1'b1;
        instruccion = 33'd0;
        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);
        wb_write(5'd6, 32'd9);

        for (int i = 0; i < 23; i++) begin
            drive(v[i]);
            #4;
            chk("pc_write", i, 32'(pc_write), 32'(v[i].pw));
            chk("if_id_write", i, 32'(if_id_write), 32'(v[i].pw));
            chk("salto_sel", i, 32'(salto_sel), 32'(v[i].ss));
            chk("if_flush", i, 32'(if_flush), 32'(v[i].ss));
            chk("pc_salto", i, 32'(pc_salto), 32'(v[i].ps));
            @(posedge clock); #1;
            chk("ex_ctl", i, 32'(ctl_bus), 32'(v[i].ctl));
            chk("ex_dato_a", i, ex_dato_a, v[i].da);
            chk("ex_pc", i, 32'(ex_pc), 32'(v[i].pc));
            if (v[i].ci) chk("ex_inmediato", i, ex_inmediato, v[i].imm);
        end

        drive('{I_ADD10, 11'h080, N,N,5'd0, N,N,5'd0,32'd0, N,5'd0,32'd0, N,N,11'h0, C_Z,32'd0, N,32'd0});
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("rst2_ex_ctl", 99, 32'(ctl_bus), 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("rf_cleared_r1", 99, ex_dato_a, 32'd0);
        chk("rf_cleared_ctl", 99, 32'(ctl_bus), 32'(C_RADD));
        instruccion = I_ADD35;
        @(posedge clock); #1;
        chk("rf_cleared_r5", 99, ex_dato_a, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instruction_decode.md
# instruction_decode

Second pipeline stage: consumes the IF/ID instruction and PC, reads the register file, decodes control, resolves branches and jumps in ID, detects hazards, and registers everything into the ID/EX register. It drives the stall/flush/redirect controls back into the fetch stage (`pc_write`, `if_id_write`, `if_flush`, `salto_sel`, `pc_salto`).

## Interface
Parameters: none; widths are fixed by the shared package.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low.
- `pc` in 11: word address of the IF/ID instruction plus 1.
- `instruccion` in 33: bit 32 is the valid bit (0 means bubble); bits 31:0 are the MIPS-I word.
- `ex_mem_read`, `ex_reg_write` in 1: control bits of the instruction currently in EX, fed back from the ID/EX outputs.
- `ex_rd_dest` in 5: destination register selected in EX, after the `reg_dst` mux.
- `mem_reg_write`, `mem_mem_read` in 1; `mem_rd` in 5; `mem_dato` in 32: MEM-stage destination and ALU result.
- `wb_reg_write` in 1; `wb_rd` in 5; `wb_dato` in 32: write-back port.
- `pc_salto` out 11; `salto_sel`, `if_flush`, `pc_write`, `if_id_write` out 1: controls to fetch (combinational).
- `ex_pc` out 11; `ex_dato_a`, `ex_dato_b`, `ex_inmediato` out 32; `ex_rs`, `ex_rt`, `ex_rd` out 5; `ex_shamt` out 5: ID/EX datapath.
- `ex_ctl_reg_write`, `ex_ctl_mem_read`, `ex_ctl_mem_write`, `ex_ctl_mem_to_reg`, `ex_ctl_alu_src`, `ex_ctl_reg_dst` out 1; `ex_ctl_alu_op` out 4: ID/EX control.

## Operation
- Register file: 32×32. r0 always reads 0 and writes to it are ignored. A write occurs on the clock edge when `wb_reg_write` is high and `wb_rd` is non-zero. A same-cycle read of `wb_rd` returns `wb_dato` (write-through bypass). Reset clears all registers.
- Decoded opcodes: R-type 0x00; lw 0x23; sw 0x2B; beq 0x04; bne 0x05; addi 0x08; slti 0x0A; andi 0x0C; ori 0x0D; lui 0x0F; j 0x02.
- Any other opcode, or bit 32 = 0, becomes a bubble: all control bits 0.
- ALU op encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLL 7, SRL 8, SRA 9, LUI 10.
  - R-type funct mapping: 0x20/0x21→ADD, 0x22/0x23→SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL, 0x03 SRA. Unknown funct produces a bubble.
- Immediate extension: andi and ori zero-extend; all other I-types sign-extend.
- Branch compare operands: use MEM forwarding when `mem_reg_write` is high, `mem_rd` is non-zero, `mem_rd` matches the source register, and `mem_mem_read` is 0. Otherwise use the register file output.
- Branch target: `pc + imm[10:0]`, modulo 2^11. Jump target: `instr[10:0]`.
- Load-use stall:
  - Condition: `ex_mem_read` is high, `ex_rd_dest` is non-zero, and `ex_rd_dest` equals rs, or equals rt when rt is a source (R-type, beq, bne, sw).
- Branch stall (beq/bne only):
  - `ex_reg_write` is high and `ex_rd_dest` is non-zero and matches rs or rt; or
  - `mem_mem_read` is high and `mem_rd` is non-zero and matches rs or rt.
- Stall response: `pc_write`=0, `if_id_write`=0, bubble into ID/EX, `salto_sel`=0, `if_flush`=0. A stall overrides any redirect.
- Redirect (taken beq/bne, or j, with no stall): `salto_sel`=1, `if_flush`=1, `pc_salto`=target. The branch/jump itself enters ID/EX as a bubble.
- Otherwise: `pc_write`=1, `if_id_write`=1, `salto_sel`=0, `if_flush`=0, and `pc_salto`=0.

## Timing
- Control outputs to fetch are combinational within the same cycle.
- ID/EX outputs are registered, with 1-cycle latency.
- Reset (`reset_n`=0 at an edge): every `ex_*` output becomes 0 and the register file is cleared. While `reset_n`=0, `pc_write`=1, `if_id_write`=1, `salto_sel`=0, `if_flush`=0, `pc_salto`=0.
- Simultaneous WB write and branch compare on the same register: the compare sees the new value through the bypass.
- A load-use stall lasts exactly 1 cycle.
- Branch stall length: 1 cycle behind an ALU op in EX; 2 cycles behind a load in EX (EX stall, then MEM-load stall).

## Structure
- Package `pipeline_pkg`: opcode and funct constants, the ALU-op encoding, a packed control struct `ctl_t` (7 fields), and width constants (PC 11, instruction 33, data 32).
- Sub-module `register_file`: 2 read ports and 1 write port, with bypass and synchronous reset.
- Top level contains the decoder, hazard unit, branch unit, and ID/EX register.

## Test plan
- Write-back bypass: `wb_reg_write`=1, `wb_rd`=5, `wb_dato`=0x1234, while decoding add r3,r5,r0 → next cycle `ex_dato_a`=0x1234, `ex_ctl_alu_op`=0, `ex_ctl_reg_write`=1.
- Load-use: lw r2 in EX (`ex_mem_read`=1, `ex_rd_dest`=2) while sub r4,r2,r1 is in ID → `pc_write`=0, `if_id_write`=0; next cycle all `ex_ctl_*`=0.
- beq taken: r1=r2=7, instruction beq r1,r2,+4 with `pc`=0x010 → `salto_sel`=1, `if_flush`=1, `pc_salto`=0x014.
- beq with MEM forwarding: `mem_rd`=1, `mem_dato`=9, r2=9 → branch taken.
- Stall priority: `ex_reg_write`=1, `ex_rd_dest`=1, and beq r1 in ID → `salto_sel`=0; after the stall, the branch resolves.
- Reset and bubble handling:
  - j 0x3FF with `reset_n`=0 → all outputs at reset values, `salto_sel`=0.
  - Instruction with bit 32=0 → bubble, no redirect.
